// File: rtl/rs232_tx.sv
`default_nettype none
// ============================================================================
// Module   : rs232_tx
// Purpose  : Buffered 8N1 serial transmitter. Bytes pushed on din/wr are
//            queued in a 2^logDepth-deep FIFO and shifted out LSB-first on
//            TxD, bitTime clocks per bit, back-to-back with no idle gap.
// Options  : Define RS232_TX_PARITY_EN to insert an even-parity bit between
//            the last data bit and the stop bit (11-bit frames).
// Revision : 1.0 - initial release
// ============================================================================
module rs232_tx #(
    parameter int bitTime  = 868,
    parameter int logDepth = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       TxD
);

    localparam int          c_DEPTH    = 1 << logDepth;
    localparam logic [15:0] c_BIT_LAST = 16'(bitTime - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef RS232_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [c_DEPTH];
    logic [logDepth-1:0] r_wr_ptr;
    logic [logDepth-1:0] r_rd_ptr;
    logic [logDepth:0]   r_count;

    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [7:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_clk_cnt;
    logic        r_txd;

    logic [2:0]  w_state_nxt;
    logic [7:0]  w_sr_nxt;
    logic [2:0]  w_bit_nxt;
    logic [15:0] w_clk_nxt;
    logic        w_txd_nxt;
    logic        w_bit_end;

`ifdef RS232_TX_PARITY_EN
    logic        r_par;
`endif

    // Status flags are plain decodes of the registered occupancy count.
    assign full   = (r_count == {1'b1, {logDepth{1'b0}}});
    assign empty  = (r_count == '0);
    assign busy   = (r_state != c_IDLE);
    assign TxD    = r_txd;

    // A write seen while full is dropped, even if a pop shares the edge.
    assign w_push    = wr & ~full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_clk_cnt == c_BIT_LAST);

    // FIFO data array; contents need no reset because count gates reads.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer register bank; TxD comes straight from r_txd.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

`ifdef RS232_TX_PARITY_EN
    // Even parity of the byte is captured when it leaves the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= ^w_head;
        end
    end
`endif

    // Next-state logic: bit boundaries fall where the clock counter wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bit_nxt   = r_bit_cnt;
        w_clk_nxt   = r_clk_cnt;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;

        if (r_state != c_IDLE) begin
            w_clk_nxt = w_bit_end ? 16'd0 : r_clk_cnt + 16'd1;
        end

        case (r_state)
            c_IDLE: begin
                w_txd_nxt = 1'b1;
                w_clk_nxt = 16'd0;
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_sr_nxt    = w_head;
                    w_state_nxt = c_START;
                    w_txd_nxt   = 1'b0;
                end
            end

            c_START: begin
                if (w_bit_end) begin
                    w_state_nxt = c_DATA;
                    w_txd_nxt   = r_sr[0];
                    w_bit_nxt   = 3'd0;
                end
            end

            c_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                        w_state_nxt = c_PARITY;
                        w_txd_nxt   = r_par;
`else
                        w_state_nxt = c_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_sr_nxt  = {1'b0, r_sr[7:1]};
                        w_txd_nxt = r_sr[1];
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end

`ifdef RS232_TX_PARITY_EN
            c_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = c_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif

            c_STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        w_pop       = 1'b1;
                        w_sr_nxt    = w_head;
                        w_state_nxt = c_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_txd_nxt   = 1'b1;
                w_clk_nxt   = 16'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
